// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store with one RW port, per-way write mask,
// registered tag compare and an init/flush sweep that clears all valid bits.
module cache_tag_array_nway #(
    parameter int WAYS      = 4,
    parameter int SETS      = 16,
    parameter int TAG_WIDTH = 23
) (
    input  logic                      clk0,
    input  logic                      rst0_n,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [$clog2(SETS)-1:0]   addr0,
    input  logic [WAYS-1:0]           wmask0,
    input  logic [TAG_WIDTH-1:0]      din0,
    input  logic                      vin0,
    input  logic                      flush0,
    output logic                      ready0,
    output logic [WAYS*TAG_WIDTH-1:0] dout0,
    output logic [WAYS-1:0]           valid0,
    output logic [WAYS-1:0]           hit0,
    output logic                      hit_any0
);
    localparam int SET_BITS = $clog2(SETS);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                 state_q;
    logic [SET_BITS-1:0]    idx_q;
    logic                   have_q;
    logic                   wr_pend_q;
    logic [SET_BITS-1:0]    addr_q;
    logic [WAYS-1:0]        mask_q;
    logic [TAG_WIDTH-1:0]   din_q;
    logic                   vin_q;

    logic [TAG_WIDTH-1:0]   tag_mem [SETS][WAYS];
    logic [WAYS-1:0]        vld_mem [SETS];

    logic                   accept;
    logic                   show;

    assign accept = (state_q == ST_READY) && !csb0 && !flush0;
    assign ready0 = (state_q == ST_READY);
    // Outputs only carry data once a request has been accepted in READY.
    assign show   = (state_q == ST_READY) && have_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            have_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            din_q     <= '0;
            vin_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    idx_q     <= idx_q + 1'b1;
                    have_q    <= 1'b0;
                    wr_pend_q <= 1'b0;
                    if (idx_q == SET_BITS'(SETS - 1))
                        state_q <= ST_READY;
                end
                default: begin
                    if (flush0) begin
                        state_q   <= ST_INIT;
                        idx_q     <= '0;
                        have_q    <= 1'b0;
                        wr_pend_q <= 1'b0;
                    end else if (accept) begin
                        have_q    <= 1'b1;
                        wr_pend_q <= !web0;
                        addr_q    <= addr0;
                        mask_q    <= wmask0;
                        din_q     <= din0;
                        vin_q     <= vin0;
                    end else begin
                        wr_pend_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A write accepted on one edge commits on the next, including a flush edge.
    always_ff @(posedge clk0) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_pend_q && mask_q[w]) begin
                tag_mem[addr_q][w] <= din_q;
                vld_mem[addr_q][w] <= vin_q;
            end
        end
        if (state_q == ST_INIT)
            vld_mem[idx_q] <= '0;
    end

    genvar gw;
    generate
        for (gw = 0; gw < WAYS; gw++) begin : g_way
            logic [TAG_WIDTH-1:0] tag_w;
            logic                 vld_w;
            // Merge the uncommitted write so the outputs show post-write contents.
            always_comb begin
                tag_w = tag_mem[addr_q][gw];
                vld_w = vld_mem[addr_q][gw];
                if (wr_pend_q && mask_q[gw]) begin
                    tag_w = din_q;
                    vld_w = vin_q;
                end
            end
            assign dout0[gw*TAG_WIDTH +: TAG_WIDTH] = show ? tag_w : '0;
            assign valid0[gw] = show && vld_w;
            assign hit0[gw]   = show && vld_w && (tag_w == din_q);
        end
    endgenerate

    assign hit_any0 = |hit0;

endmodule

// File: tb/tb_cache_tag_array_nway.sv
// Directed scoreboard bench for cache_tag_array_nway: stimulus pushes expected
// responses, a monitor pops and compares on every accepted request.
module tb_cache_tag_array_nway;
    localparam int W = 4;
    localparam int T = 23;
    localparam logic [T-1:0] TM = 23'h7FFFFF;

    logic           clk0 = 1'b0;
    logic           rst0_n;
    logic           csb0, web0, vin0, flush0;
    logic [3:0]     addr0;
    logic [W-1:0]   wmask0;
    logic [T-1:0]   din0;
    logic           ready0, hit_any0;
    logic [W*T-1:0] dout0;
    logic [W-1:0]   valid0, hit0;

    cache_tag_array_nway #(.WAYS(W), .SETS(16), .TAG_WIDTH(T)) dut (
        .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0), .addr0(addr0),
        .wmask0(wmask0), .din0(din0), .vin0(vin0), .flush0(flush0),
        .ready0(ready0), .dout0(dout0), .valid0(valid0), .hit0(hit0),
        .hit_any0(hit_any0)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        string          nm;
        logic [W*T-1:0] d;
        logic [W*T-1:0] dm;
        logic [W-1:0]   v;
        logic [W-1:0]   h;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    logic acc    = 1'b0;

    function automatic logic [W*T-1:0] mk(input logic [T-1:0] t0, t1, t2, t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Monitor: a request is accepted on a posedge with ready0, csb0=0, no flush.
    always @(posedge clk0) acc <= rst0_n && ready0 && !csb0 && !flush0;

    always @(negedge clk0) begin
        if (acc) begin
            n_tot++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_response: valid0=%b hit0=%b with empty queue", valid0, hit0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (((dout0 & e.dm) === (e.d & e.dm)) && valid0 === e.v &&
                    hit0 === e.h && hit_any0 === (|e.h))
                    n_pass++;
                else
                    $display("FAIL %s: dout0=%h valid0=%b hit0=%b hit_any0=%b expected dout0=%h (mask %h) valid0=%b hit0=%b",
                             e.nm, dout0, valid0, hit0, hit_any0, e.d, e.dm, e.v, e.h);
            end
        end
    end

    task automatic req(input string nm, input logic we, input logic [3:0] a,
                       input logic [W-1:0] m, input logic [T-1:0] d, input logic vi,
                       input logic [W*T-1:0] ed, input logic [W*T-1:0] edm,
                       input logic [W-1:0] ev, input logic [W-1:0] eh);
        exp_t e;
        @(negedge clk0);
        csb0 = 1'b0; web0 = !we; addr0 = a; wmask0 = m; din0 = d; vin0 = vi;
        e.nm = nm; e.d = ed; e.dm = edm; e.v = ev; e.h = eh;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk0);
        csb0 = 1'b1; web0 = 1'b1; flush0 = 1'b0;
    endtask

    // Counts posedges until ready0 rises, bounded.
    task automatic count_sweep(input string nm);
        int n = 0;
        do begin
            @(posedge clk0); #1; n++;
        end while (!ready0 && n < 100);
        chk(nm, 128'(n), 128'd16);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {dout0, valid0, hit0, hit_any0, ready0}, '0);
    endtask

    initial begin
        rst0_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; flush0 = 1'b0;
        addr0 = '0; wmask0 = '0; din0 = '0; vin0 = 1'b0;
        repeat (3) @(negedge clk0);
        chk_zero("reset_outputs");
        rst0_n = 1'b1;
        count_sweep("init_sweep_len");

        req("rd_after_init", 1'b0, 4'd7, 4'b0000, 23'h0, 1'b0, '0, '0, 4'b0000, 4'b0000);

        req("wr_set3_0101", 1'b1, 4'd3, 4'b0101, 23'h12345, 1'b1,
            mk(23'h12345, 0, 23'h12345, 0), mk(TM, 0, TM, 0), 4'b0101, 4'b0101);
        req("rd_set3_hit", 1'b0, 4'd3, 4'b0000, 23'h12345, 1'b0,
            mk(23'h12345, 0, 23'h12345, 0), mk(TM, 0, TM, 0), 4'b0101, 4'b0101);
        req("rd_set3_miss", 1'b0, 4'd3, 4'b0000, 23'h54321, 1'b0,
            mk(23'h12345, 0, 23'h12345, 0), mk(TM, 0, TM, 0), 4'b0101, 4'b0000);
        req("wr_set3_way1", 1'b1, 4'd3, 4'b0010, 23'h00ABC, 1'b1,
            mk(23'h12345, 23'h00ABC, 23'h12345, 0), mk(TM, TM, TM, 0), 4'b0111, 4'b0010);
        req("wr_mask0_noop", 1'b1, 4'd3, 4'b0000, 23'h12345, 1'b0,
            mk(23'h12345, 23'h00ABC, 23'h12345, 0), mk(TM, TM, TM, 0), 4'b0111, 4'b0101);
        req("wr_invalidate_w0", 1'b1, 4'd3, 4'b0001, 23'h12345, 1'b0,
            mk(23'h12345, 23'h00ABC, 23'h12345, 0), mk(TM, TM, TM, 0), 4'b0110, 4'b0100);

        req("wr_set5_max", 1'b1, 4'd5, 4'b0100, 23'h7FFFFF, 1'b1,
            mk(0, 0, 23'h7FFFFF, 0), mk(0, 0, TM, 0), 4'b0100, 4'b0100);
        req("rd_set5_b2b", 1'b0, 4'd5, 4'b0000, 23'h7FFFFF, 1'b0,
            mk(0, 0, 23'h7FFFFF, 0), mk(0, 0, TM, 0), 4'b0100, 4'b0100);

        req("wr_set9_inval", 1'b1, 4'd9, 4'b0010, 23'h00001, 1'b0,
            mk(0, 23'h00001, 0, 0), mk(0, TM, 0, 0), 4'b0000, 4'b0000);
        req("rd_set9_nohit", 1'b0, 4'd9, 4'b0000, 23'h00001, 1'b0,
            mk(0, 23'h00001, 0, 0), mk(0, TM, 0, 0), 4'b0000, 4'b0000);

        for (int s = 0; s < 16; s++) begin
            logic [T-1:0] t;
            t = T'(32'h100 + s);
            req($sformatf("fill_set%0d", s), 1'b1, 4'(s), 4'b1111, t, 1'b1,
                mk(t, t, t, t), mk(TM, TM, TM, TM), 4'b1111, 4'b1111);
        end
        req("rd_set10_full", 1'b0, 4'd10, 4'b0000, 23'h10A, 1'b0,
            mk(23'h10A, 23'h10A, 23'h10A, 23'h10A), mk(TM, TM, TM, TM), 4'b1111, 4'b1111);
        req("wr_set2_preflush", 1'b1, 4'd2, 4'b0001, 23'h2AAAA, 1'b1,
            mk(23'h2AAAA, 23'h102, 23'h102, 23'h102), mk(TM, TM, TM, TM), 4'b1111, 4'b0001);

        @(negedge clk0);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd4; din0 = 23'h104; flush0 = 1'b1;
        @(negedge clk0);
        csb0 = 1'b1; flush0 = 1'b0;
        chk("flush_ready_low", 128'(ready0), 128'd0);
        @(posedge clk0);
        begin
            int n = 1;
            #1;
            while (!ready0 && n < 100) begin
                @(posedge clk0); #1; n++;
            end
            chk("flush_sweep_len", 128'(n), 128'd16);
        end

        req("rd_set3_flushed", 1'b0, 4'd3, 4'b0000, 23'h103, 1'b0,
            mk(23'h103, 23'h103, 23'h103, 23'h103), mk(TM, TM, TM, TM), 4'b0000, 4'b0000);
        req("rd_set2_commit", 1'b0, 4'd2, 4'b0000, 23'h2AAAA, 1'b0,
            mk(23'h2AAAA, 23'h102, 23'h102, 23'h102), mk(TM, TM, TM, TM), 4'b0000, 4'b0000);

        req("wr_set2_all", 1'b1, 4'd2, 4'b1111, 23'h55555, 1'b1,
            mk(23'h55555, 23'h55555, 23'h55555, 23'h55555), mk(TM, TM, TM, TM), 4'b1111, 4'b1111);
        idle();
        @(negedge clk0);
        #2 rst0_n = 1'b0;
        #1 chk_zero("async_reset_ready");
        repeat (2) @(negedge clk0);
        rst0_n = 1'b1;
        count_sweep("sweep_after_reset");

        flush0 = 1'b0;
        @(negedge clk0);
        flush0 = 1'b1;
        @(negedge clk0);
        flush0 = 1'b0;
        repeat (7) @(posedge clk0);
        #2 rst0_n = 1'b0;
        #1 chk_zero("async_reset_midsweep");
        repeat (2) @(negedge clk0);
        rst0_n = 1'b1;
        count_sweep("sweep_restart");

        req("rd_set2_post_reset", 1'b0, 4'd2, 4'b0000, 23'h55555, 1'b0,
            '0, '0, 4'b0000, 4'b0000);
        idle();

        begin
            int guard = 0;
            while (q.size() != 0 && guard < 50) begin
                @(negedge clk0); guard++;
            end
            if (q.size() != 0) begin
                n_tot++;
                $display("FAIL drain: %0d responses never observed, expected 0", q.size());
            end
        end
        repeat (2) @(negedge clk0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
